// File: rtl/paralelo_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : paralelo_serial_if
//  Description : Byte-push / serial-line bundle between the lane logic and
//                the paralelo_serial transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface paralelo_serial_if;
    logic [7:0] data_in;   // byte to enqueue
    logic       valid_in;  // push request
    logic       full;      // FIFO holds DEPTH bytes
    logic       data_out;  // serial line, MSB first
    logic       active;    // comma preamble finished
    logic       err_bc;    // dropped 0xBC push pulse
    logic       overflow;  // dropped push-while-full pulse

    // Lane-logic side: produces bytes, observes status and the line.
    modport master (
        output data_in,
        output valid_in,
        input  full,
        input  data_out,
        input  active,
        input  err_bc,
        input  overflow
    );

    // Serializer side.
    modport slave (
        input  data_in,
        input  valid_in,
        output full,
        output data_out,
        output active,
        output err_bc,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module      : paralelo_serial
//  Description : Transmit serializer. Sends SYNC_COUNT 0xBC commas after
//                reset, then queued bytes MSB first, with 0xBC idles whenever
//                the byte FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module paralelo_serial #(
    parameter int DEPTH      = 4,
    parameter int SYNC_COUNT = 4
) (
    input  wire logic         clk_32f,
    input  wire logic         reset,
    paralelo_serial_if.slave  bus
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         CW      = AW + 1;
    localparam int         SW      = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT + 1) : 1;
    localparam logic [7:0] C_COMMA = 8'hBC;

    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [SW-1:0]   sync_cnt_q, sync_cnt_d;
    logic [2:0]      bit_cnt_q,  bit_cnt_d;
    logic [7:0]      shreg_q,    shreg_d;
    logic            data_out_q, data_out_d;
    logic            active_q,   active_d;
    logic            err_bc_q,   err_bc_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [7:0]      mem_q [DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_load;
    logic            w_is_comma;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_byte;

    // Push/pop qualification; full is taken from the pre-edge count so a
    // pop on the same edge never frees a slot for a push.
    assign w_full     = (count_q == CW'(DEPTH));
    assign w_empty    = (count_q == '0);
    assign w_load     = (bit_cnt_q == 3'd0);
    assign w_is_comma = (bus.data_in == C_COMMA);
    assign w_push     = bus.valid_in && !w_is_comma && !w_full;
    assign w_pop      = w_load && (state_q == ST_ACTIVE) && !w_empty;
    assign w_byte     = (state_q == ST_ACTIVE && !w_empty) ? mem_q[rd_ptr_q] : C_COMMA;

    assign bus.full     = w_full;
    assign bus.data_out = data_out_q;
    assign bus.active   = active_q;
    assign bus.err_bc   = err_bc_q;
    assign bus.overflow = overflow_q;

    // Next-state: bit engine, comma preamble sequencing and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        shreg_d    = {shreg_q[6:0], 1'b0};
        data_out_d = shreg_q[7];
        active_d   = active_q;
        err_bc_d   = bus.valid_in && w_is_comma;
        overflow_d = bus.valid_in && !w_is_comma && w_full;
        wr_ptr_d   = wr_ptr_q + AW'(w_push);
        rd_ptr_d   = rd_ptr_q + AW'(w_pop);
        count_d    = count_q + CW'(w_push) - CW'(w_pop);

        if (w_load) begin
            data_out_d = w_byte[7];
            shreg_d    = {w_byte[6:0], 1'b0};
            case (state_q)
                ST_SYNC: begin
                    sync_cnt_d = sync_cnt_q + SW'(1);
                    if (sync_cnt_q == SW'(SYNC_COUNT - 1)) begin
                        state_d = ST_ACTIVE;
                    end
                end
                default: begin
                    active_d = 1'b1;
                end
            endcase
        end
    end

    // State register; reset abandons the byte in flight and empties the FIFO.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= ST_SYNC;
            sync_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_out_q <= 1'b0;
            active_q   <= 1'b0;
            err_bc_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            active_q   <= active_d;
            err_bc_q   <= err_bc_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; stale entries are harmless because count gates reads.
    always_ff @(posedge clk_32f) begin
        if (!reset && w_push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paralelo_serial
//  Description : Directed bench for paralelo_serial (DEPTH=4, SYNC_COUNT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paralelo_serial;
    logic clk_32f;
    logic reset;
    int   total;
    int   bad;
    logic [7:0] c_bc;

    paralelo_serial_if bus ();

    paralelo_serial #(.DEPTH(4), .SYNC_COUNT(4)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic check_bit(input logic b, input logic act, input string tag);
        tick();
        chk({tag, " data_out"}, {7'd0, bus.data_out}, {7'd0, b});
        chk({tag, " active"},   {7'd0, bus.active},   {7'd0, act});
    endtask

    task automatic check_byte(input logic [7:0] b, input logic act, input string tag);
        for (int i = 7; i >= 0; i--) begin
            check_bit(b[i], act, tag);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk("rst data_out", {7'd0, bus.data_out}, 8'd0);
        chk("rst active",   {7'd0, bus.active},   8'd0);
        chk("rst err_bc",   {7'd0, bus.err_bc},   8'd0);
        chk("rst overflow", {7'd0, bus.overflow}, 8'd0);
        chk("rst full",     {7'd0, bus.full},     8'd0);
        reset = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        c_bc         = 8'hBC;
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        tick();
        do_reset();

        // Idle after reset: four preamble commas, then idle commas with active.
        for (int m = 0; m < 5; m++) begin
            check_byte(8'hBC, (m >= 4), "idle");
        end
        chk("idle err_bc",   {7'd0, bus.err_bc},   8'd0);
        chk("idle overflow", {7'd0, bus.overflow}, 8'd0);

        // Push 0xA5 at edge 2 during SYNC; it waits for the first ACTIVE load.
        do_reset();
        check_bit(1'b1, 1'b0, "sync e1");
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hA5;
        check_bit(1'b0, 1'b0, "sync e2");
        bus.valid_in = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            check_bit(c_bc[i], 1'b0, "sync b0");
        end
        check_byte(8'hBC, 1'b0, "sync b1");
        check_byte(8'hBC, 1'b0, "sync b2");
        check_byte(8'hBC, 1'b0, "sync b3");
        check_byte(8'hA5, 1'b1, "data A5");
        check_byte(8'hBC, 1'b1, "post A5");

        // Fill the FIFO with pushes right after a load; fifth push overflows.
        check_bit(c_bc[7], 1'b1, "fill load");
        for (int i = 0; i < 5; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'(8'h11 * (i + 1));
            check_bit(c_bc[6 - i], 1'b1, "fill");
            chk("fill full", {7'd0, bus.full}, {7'd0, (i >= 3)});
            chk("fill overflow", {7'd0, bus.overflow}, {7'd0, (i == 4)});
        end
        bus.valid_in = 1'b0;
        check_bit(c_bc[1], 1'b1, "fill");
        chk("overflow clear", {7'd0, bus.overflow}, 8'd0);
        check_bit(c_bc[0], 1'b1, "fill");
        check_byte(8'h11, 1'b1, "q11");
        chk("full after pop", {7'd0, bus.full}, 8'd0);
        check_byte(8'h22, 1'b1, "q22");
        check_byte(8'h33, 1'b1, "q33");
        check_byte(8'h44, 1'b1, "q44");
        check_byte(8'hBC, 1'b1, "drained");

        // A 0xBC push is rejected with an err_bc pulse; nothing gets queued.
        check_bit(c_bc[7], 1'b1, "bc load");
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hBC;
        check_bit(c_bc[6], 1'b1, "bc push");
        chk("err_bc pulse",  {7'd0, bus.err_bc},   8'd1);
        chk("bc no ovf",     {7'd0, bus.overflow}, 8'd0);
        bus.valid_in = 1'b0;
        check_bit(c_bc[5], 1'b1, "bc push");
        chk("err_bc clear",  {7'd0, bus.err_bc},   8'd0);
        chk("bc full",       {7'd0, bus.full},     8'd0);
        for (int i = 4; i >= 0; i--) begin
            check_bit(c_bc[i], 1'b1, "bc tail");
        end
        check_byte(8'hBC, 1'b1, "bc after");

        // Queue 0x7E, 0x01, 0x02, then reset while 0x7E is at bit_cnt 4.
        check_bit(c_bc[7], 1'b1, "mid load");
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h7E;
        check_bit(c_bc[6], 1'b1, "mid q");
        bus.data_in  = 8'h01;
        check_bit(c_bc[5], 1'b1, "mid q");
        bus.data_in  = 8'h02;
        check_bit(c_bc[4], 1'b1, "mid q");
        bus.valid_in = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            check_bit(c_bc[i], 1'b1, "mid q");
        end
        check_bit(1'b0, 1'b1, "7E b7");
        check_bit(1'b1, 1'b1, "7E b6");
        check_bit(1'b1, 1'b1, "7E b5");
        check_bit(1'b1, 1'b1, "7E b4");
        do_reset();
        check_byte(8'hBC, 1'b0, "rsync0");
        check_byte(8'hBC, 1'b0, "rsync1");
        check_byte(8'hBC, 1'b0, "rsync2");
        check_byte(8'hBC, 1'b0, "rsync3");
        check_byte(8'hBC, 1'b1, "no stale");
        chk("rst fifo empty", {7'd0, bus.full}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/paralelo_serial.md
# paralelo_serial

Transmit-side serializer for the PHY link, sitting directly upstream of the phy_rx deserializer. It accepts bytes from the lane logic through a small FIFO and emits a continuous MSB-first bit stream, one bit per clk_32f cycle. After reset it sends a fixed run of 0xBC comma bytes so the receiver can lock. From then on it sends queued data bytes, and sends 0xBC idles whenever the FIFO is empty.

## Interface
Parameters:
- DEPTH, 4: FIFO depth in bytes (power of two, 2..16).
- SYNC_COUNT, 4: number of 0xBC commas sent after reset before data is allowed.

Ports:
- clk_32f  in  1  bit clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, no other clock domains.
- data_in  in  8  byte to enqueue.
- valid_in  in  1  push request; sampled every clk_32f edge.
- full  out  1  FIFO count == DEPTH (combinational from registered count).
- data_out  out  1  serial line, registered.
- active  out  1  high once SYNC_COUNT commas have been sent (state ACTIVE).
- err_bc  out  1  one-cycle pulse: a push of 0xBC was dropped.
- overflow  out  1  one-cycle pulse: a push while full was dropped.

## Operation
- Reset values (edge with reset=1): data_out=0, active=0, err_bc=0, overflow=0, bit_cnt=0, sync_cnt=0, shreg=0, FIFO count/pointers=0, state=SYNC.
- Bit engine, registers bit_cnt[2:0] and shreg[7:0]:
  - Edge with bit_cnt==0 (load edge): select byte B; data_out<=B[7]; shreg<=B<<1; bit_cnt<=1.
  - Edge with bit_cnt==k, k=1..7: data_out<=shreg[7]; shreg<=shreg<<1; bit_cnt<=(k+1) mod 8.
- Byte selection at a load edge:
  - SYNC: B=0xBC; sync_cnt++. On the load where sync_cnt==SYNC_COUNT-1, state<=ACTIVE.
  - ACTIVE, FIFO non-empty: B=head byte; pop on the same edge.
  - ACTIVE, FIFO empty: B=0xBC.
- active is registered. It goes 1 on the first ACTIVE load edge and stays 1 until reset.
- FIFO push, evaluated on every edge, in priority order:
  - valid_in && data_in==8'hBC: dropped; err_bc<=1 for one cycle. This check wins even when full.
  - valid_in && full: dropped; overflow<=1 for one cycle.
  - Otherwise, if valid_in: written at the tail; count++.
- Pushes are accepted during SYNC; those bytes are held until ACTIVE.
- Simultaneous push and pop, not full: both happen; count unchanged.
- Full plus pop on the same edge: the push is still rejected, because full reflects the pre-edge count.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH (width clog2(DEPTH)+1).
- Reset mid-byte:
  - The partial byte is abandoned and the FIFO contents are discarded.
  - On the next edge with reset=0, the SYNC sequence restarts from the first comma.

## Timing
- Edge n is the n-th rising edge after reset deasserts; n=1 is a load edge, and load edges fall at n=1+8m.
- Byte m occupies data_out from edge 1+8m through edge 8+8m, MSB first.
- Commas occupy bytes 0..SYNC_COUNT-1. active rises at edge 8*SYNC_COUNT+1 (edge 33 with defaults).
- Latency, ACTIVE state with empty FIFO:
  - A byte pushed at edge p is written at p and popped at the next load edge q > p.
  - Its MSB is on data_out after edge q.
  - Worst case is 8 edges.
- Throughput: at most one byte per 8 clk_32f cycles. A sustained push rate above 1/8 fills the FIFO.
- err_bc and overflow assert on the edge after the offending push and clear one edge later, unless the condition repeats.

## Test plan
- Reset, then idle with no pushes: data_out carries 10111100 repeating from edge 1; active=0 through edge 32 and 1 from edge 33; no err_bc or overflow pulses.
- Push 0xA5 at edge 2 (during SYNC): bytes 0..3 are 0xBC; edges 33..40 carry 1,0,1,0,0,1,0,1; byte 5 is 0xBC.
- In ACTIVE, push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive edges, with the first push at the cycle right after a load: full goes high after the 4th accepted push; the 5th is dropped with an overflow pulse; the wire carries 0x11, 0x22, 0x33, 0x44, then 0xBC.
- Push 0xBC in ACTIVE with the FIFO empty: an err_bc pulse; FIFO count stays 0; only commas appear on the wire.
- Assert reset for 1 cycle at bit_cnt==4 while 0x7E is mid-transmission and 2 bytes are queued: data_out=0 and active=0 next edge; after deassert, 4 commas are sent and no old data reappears.
- Loopback into the phy_rx deserializer, pushing 0x01..0x0A: the receiver's active rises, then it emits 0x01..0x0A with valid_out and drops valid_out during idle commas.
